cache_mem_responder: RTL and testbench

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

---
 rtl/cache_mem_responder_pkg.sv | 14 +
 rtl/cache_mem_responder_resp_mem_array.sv | 28 ++
 rtl/cache_mem_responder.sv | 99 +++++++++
 tb/tb_cache_mem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_responder_pkg.sv
// Shared definitions for the cache memory responder: FSM encoding and default sizing.
package cache_mem_responder_pkg;

  localparam int DEFAULT_DEPTH   = 64;
  localparam int DEFAULT_LATENCY = 4;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cache_mem_responder_resp_mem_array.sv
// Word-wide backing store: one write port, combinational read, asynchronous clear.
module resp_mem_array
  import cache_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cache_mem_responder.sv
// Fixed-latency memory responder: accepts one request, waits LATENCY cycles, then
// holds the response until the cache takes it.
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [31:0]      DEPTH_W  = 32'(DEPTH);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               req_write_p0;
  logic [31:0]        req_addr_p0;
  logic [31:0]        req_wdata_p0;
  logic               accept, commit, access_err, mem_we;
  logic [31:0]        mem_rdata;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= DEPTH_W);
  endfunction

  assign accept     = (state == IDLE) && req_valid;
  assign commit     = (state == WAIT) && (cnt == '0);
  assign access_err = addr_err(req_addr_p0);
  assign mem_we     = commit && req_write_p0 && !access_err;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid)  state_nxt = WAIT;
      WAIT:    if (cnt == '0)  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and response registers; an async reset drops any pending request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CNT_LOAD;
      else if ((state == WAIT) && (cnt != '0))
        cnt <= cnt - 1'b1;
      if (commit) begin
        resp_err   <= access_err;
        resp_rdata <= (access_err || req_write_p0) ? 32'h0 : mem_rdata;
      end
    end
  end

  // Request capture: only the accepting edge loads, so inputs outside IDLE are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_write_p0 <= req_write;
      req_addr_p0  <= req_addr;
      req_wdata_p0 <= req_wdata;
    end
  end

  resp_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .addr  (req_addr_p0[AW+1:2]),
    .wdata (req_wdata_p0),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: default instance (LATENCY 4) plus a LATENCY 1 instance.
module tb_cache_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err, busy;
  logic [31:0] req_addr, req_wdata, resp_rdata;

  logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_err1, busy1;
  logic [31:0] req_addr1, req_wdata1, resp_rdata1;

  cache_mem_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  cache_mem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1),
    .resp_err(resp_err1), .busy(busy1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [64];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = 32'h0;
  endtask

  // One full transaction on the LATENCY 4 instance; junk keeps req_valid high with
  // shifting write requests while the responder is busy.
  task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int stall, input logic junk);
    exp_t        e;
    logic [31:0] r0;
    logic        v0;
    int          n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = 1'b0;
    check_eq("req_ready_idle", req_ready, 1);
    @(posedge clk);
    e.err   = (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'd64);
    e.rdata = (e.err || w) ? 32'h0 : model[a[7:2]];
    if (!e.err && w) model[a[7:2]] = d;
    sb.push_back(e);
    n = 0;
    while (n < 20) begin
      #1;
      if (resp_valid) break;
      if (junk) begin
        req_write = 1'b1;
        req_addr  = (n % 2 == 0) ? 32'h20 : 32'h24;
        req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk);
      n++;
    end
    check_eq("latency", 32'(n), 32'd4);
    r0 = resp_rdata;
    v0 = resp_err;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check_eq("bp_valid", resp_valid, 1);
      check_eq("bp_rdata", resp_rdata, r0);
      check_eq("bp_err", resp_err, v0);
      check_eq("bp_req_ready", req_ready, 0);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    check_eq("sb_size", 32'(sb.size()), 32'd1);
    e = sb.pop_front();
    check_eq("rdata", resp_rdata, e.rdata);
    check_eq("err", resp_err, e.err);
    @(posedge clk);
    #1;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_ready", req_ready, 1);
    check_eq("idle_valid", resp_valid, 0);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    req_valid1 = 0; req_write1 = 0; req_addr1 = 0; req_wdata1 = 0; resp_ready1 = 0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_err", resp_err, 0);
    check_eq("rst1_req_ready", req_ready1, 1);

    // Reset during the WAIT of a write must leave word 4 cleared.
    run_req(1'b1, 32'h10, 32'h11112222, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h33334444;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_resp_valid", resp_valid, 0);
    check_eq("midrst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check_eq("midrst_no_resp", resp_valid, 0);
    end
    run_req(1'b0, 32'h10, 32'h0, 0, 1'b0);

    // Write then read, then the same read under backpressure.
    run_req(1'b1, 32'h3C, 32'hDEADBEEF, 0, 1'b0);
    run_req(1'b0, 32'h3C, 32'h0, 0, 1'b0);
    run_req(1'b0, 32'h3C, 32'h0, 5, 1'b0);

    // Error cases; 0x100 would alias word 0 if the range check were missing.
    run_req(1'b1, 32'h00, 32'hA5A5A5A5, 0, 1'b0);
    run_req(1'b0, 32'h102, 32'h0, 0, 1'b0);
    run_req(1'b0, 32'h100, 32'h0, 0, 1'b0);
    run_req(1'b1, 32'h100, 32'hFFFFFFFF, 0, 1'b0);
    run_req(1'b1, 32'h3D, 32'h0BADF00D, 0, 1'b0);
    run_req(1'b0, 32'h00, 32'h0, 0, 1'b0);
    run_req(1'b0, 32'h3C, 32'h0, 0, 1'b0);
    run_req(1'b0, 32'hFC, 32'h0, 0, 1'b0);

    // Requests presented while busy must be dropped.
    run_req(1'b1, 32'h40, 32'h12345678, 0, 1'b0);
    run_req(1'b0, 32'h40, 32'h0, 0, 1'b1);
    run_req(1'b0, 32'h20, 32'h0, 0, 1'b0);
    run_req(1'b0, 32'h24, 32'h0, 0, 1'b0);

    // LATENCY 1 instance: one-edge latency and back-to-back acceptance.
    @(negedge clk);
    req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 32'h8; req_wdata1 = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check_eq("l1_wait_busy", busy1, 1);
    check_eq("l1_wait_valid", resp_valid1, 0);
    check_eq("l1_wait_ready", req_ready1, 0);
    @(posedge clk);
    #1;
    check_eq("l1_resp_valid", resp_valid1, 1);
    check_eq("l1_resp_rdata", resp_rdata1, 32'h0);
    check_eq("l1_resp_err", resp_err1, 0);
    @(negedge clk);
    resp_ready1 = 1'b1;
    req_write1  = 1'b0;
    @(posedge clk);
    #1;
    check_eq("l1_hs_valid", resp_valid1, 0);
    check_eq("l1_hs_ready", req_ready1, 1);
    @(posedge clk);
    #1;
    check_eq("l1_reaccept_busy", busy1, 1);
    check_eq("l1_reaccept_ready", req_ready1, 0);
    @(negedge clk);
    req_valid1  = 1'b0;
    resp_ready1 = 1'b0;
    @(posedge clk);
    #1;
    check_eq("l1_rd_valid", resp_valid1, 1);
    check_eq("l1_rd_rdata", resp_rdata1, 32'hCAFEF00D);
    @(negedge clk);
    resp_ready1 = 1'b1;
    @(posedge clk);
    #1 check_eq("l1_done_busy", busy1, 0);
    @(negedge clk);
    resp_ready1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
